// File: rtl/aes128_encrypt_iter.sv
// aes128_encrypt_iter: iterative FIPS-197 AES-128 encryptor, one round per clock.
// Accepts a plaintext/key pair in IDLE, runs 10 rounds in ROUND, and holds the
// ciphertext in DONE until the downstream handshake.
// Build option: define AES_ENC_ZEROIZE_EN to clear the state, key and ciphertext
// registers on the output handshake, so en_msg reads 0 whenever out_valid is low.
module aes128_encrypt_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_msg,
    input  logic [127:0] cipher_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] en_msg
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t         fsm;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [127:0] sb_vec;
    logic [127:0] sr_vec;
    logic [127:0] mc_vec;
    logic [127:0] next_key;
    logic [127:0] next_state;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  key_temp;
    logic [31:0]  nk0, nk1, nk2, nk3;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply in GF(2^8).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] t;
        acc = 8'h00;
        t   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ t;
            t = xtime(t);
        end
        return acc;
    endfunction

    // S-box computed arithmetically: multiplicative inverse (a^254, with 0 -> 0)
    // followed by the affine transform. Purely combinational, no lookup ROM.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] pw;
        logic [7:0] inv;
        pw  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte i of a block lives in bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL + ROW) % 4);
            assign sb_vec[127-8*gi -: 8] = sbox(state_reg[127-8*gi -: 8]);
            assign sr_vec[127-8*gi -: 8] = sb_vec[127-8*SRC -: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_mix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr_vec[127-32*gi -: 8];
            assign a1 = sr_vec[119-32*gi -: 8];
            assign a2 = sr_vec[111-32*gi -: 8];
            assign a3 = sr_vec[103-32*gi -: 8];
            assign mc_vec[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mc_vec[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mc_vec[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mc_vec[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
        end
    endgenerate

    // On-the-fly key expansion: key_reg holds the previous round key.
    assign rot_word   = {key_reg[23:0], key_reg[31:24]};
    assign key_temp   = sub_word ^ {rcon, 24'h000000};
    assign nk0        = key_reg[127:96] ^ key_temp;
    assign nk1        = key_reg[95:64]  ^ nk0;
    assign nk2        = key_reg[63:32]  ^ nk1;
    assign nk3        = key_reg[31:0]   ^ nk2;
    assign next_key   = {nk0, nk1, nk2, nk3};

    // The final round omits MixColumns.
    assign next_state = ((round == 4'd10) ? sr_vec : mc_vec) ^ next_key;

    // Round constant for the round currently being computed.
    always_comb begin
        rcon = 8'h00;
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Control FSM with registered handshake outputs and round datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            round     <= 4'd0;
            state_reg <= '0;
            key_reg   <= '0;
            en_msg    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_msg ^ cipher_key;
                        key_reg   <= cipher_key;
                        round     <= 4'd1;
                        in_ready  <= 1'b0;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= next_state;
                    key_reg   <= next_key;
                    if (round == 4'd10) begin
                        round     <= 4'd0;
                        en_msg    <= next_state;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
`ifdef AES_ENC_ZEROIZE_EN
                        state_reg <= '0;
                        key_reg   <= '0;
                        en_msg    <= '0;
`endif
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// tb_aes128_encrypt_iter: randomized and directed bench for aes128_encrypt_iter.
// The reference is a byte-array AES-128 model (table S-box built from the
// generator-3 walk, full key expansion, matching inverse cipher).
// Honours AES_ENC_ZEROIZE_EN for the expected idle value of en_msg.
module tb_aes128_encrypt_iter;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_ENC_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_msg;
    logic [127:0] cipher_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] en_msg;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] sbox_tab [256];
    logic [7:0] inv_tab  [256];

    always #5 clk = ~clk;

    aes128_encrypt_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_msg     (in_msg),
        .cipher_key (cipher_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .en_msg     (en_msg)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] q, input int n);
        logic [15:0] d;
        d = {q, q};
        return d[15-n -: 8];
    endfunction

    // Carry-less product then reduction by 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    // Walk p over all nonzero elements (powers of 3) and q over their inverses.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_tab[p] = x ^ 8'h63;
        end
        sbox_tab[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_tab[sbox_tab[i]] = 8'(i);
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int n = 1; n <= r; n++) begin
            t = {w[3][23:0], w[3][31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                ^ {rc, 24'h000000};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc   = gmul(rc, 8'h02);
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk;
        logic [127:0] res;
        rk = round_key(key, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w+4*c] = sbox_tab[s[w+4*((c+w)%4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end
            end else begin
                s = t;
            end
            rk = round_key(key, r);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk;
        logic [127:0] res;
        rk = round_key(key, 10);
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) t[w+4*((c+w)%4)] = inv_tab[s[w+4*c]];
            rk = round_key(key, r);
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ rk[127-8*i -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
                    s[4*c+1] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
                    s[4*c+2] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
                    s[4*c+3] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
                end
            end else begin
                s = t;
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers (called right after a falling edge) ----------------
    task automatic present(input logic [127:0] pt, input logic [127:0] key);
        in_valid   = 1'b1;
        in_msg     = pt;
        cipher_key = key;
        @(negedge clk);
        in_valid   = 1'b0;
        in_msg     = {$urandom, $urandom, $urandom, $urandom};
        cipher_key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // k = number of falling edges since the accepting rising edge (1 = just after it).
    task automatic wait_valid(input int limit, output int k, output bit got);
        k   = 1;
        got = 1'b0;
        while (k <= limit && !got) begin
            if (out_valid === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int k;
        bit got;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_msg = '0; cipher_key = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (en_msg !== '0) begin n_miss++; $display("FAIL reset_en_msg: got %h want 0", en_msg); end
        rst_n = 1'b1; in_valid = 1'b1; in_msg = P1; cipher_key = K1;
        n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL first_edge_accept: in_ready got %b want 0", in_ready); end
        out_ready = 1'b1;
        wait_valid(20, k, got);
        n_vec++; if (!got || k != 11) begin n_miss++; $display("FAIL first_accept_latency: got %0d want 11", got ? k : -1); end
        n_vec++; if (en_msg !== C1) begin n_miss++; $display("FAIL first_accept_ct: got %h want %h", en_msg, C1); end
        @(negedge clk);
        $display("reset test: block after release ct=%h", C1);
    endtask

    task automatic test_kat_latency();
        int k;
        bit got;
        out_ready = 1'b1;
        present(P1, K1);
        wait_valid(20, k, got);
        n_vec++; if (!got || k != 11) begin n_miss++; $display("FAIL kat1_latency: got %0d want 11", got ? k : -1); end
        n_vec++; if (en_msg !== C1) begin n_miss++; $display("FAIL kat1_ct: got %h want %h", en_msg, C1); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_miss++; $display("FAIL kat1_one_cycle: out_valid=%b in_ready=%b want 0,1", out_valid, in_ready); end
        n_vec++; if (en_msg !== (ZEROIZE ? 128'h0 : C1)) begin n_miss++; $display("FAIL kat1_idle_msg: got %h want %h", en_msg, ZEROIZE ? 128'h0 : C1); end
        $display("kat1: pt=%h key=%h ct=%h latency=%0d", P1, K1, en_msg, k - 1);
    endtask

    task automatic test_stall();
        int k;
        bit got;
        out_ready = 1'b0;
        present(P2, K2);
        wait_valid(20, k, got);
        n_vec++; if (!got || k != 11) begin n_miss++; $display("FAIL kat2_latency: got %0d want 11", got ? k : -1); end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || en_msg !== C2) begin
                n_miss++;
                $display("FAIL stall_hold_%0d: out_valid=%b in_ready=%b en_msg=%h want 1,0,%h", i, out_valid, in_ready, en_msg, C2);
            end
            @(negedge clk);
        end
        n_vec++; if (out_valid !== 1'b1 || en_msg !== C2) begin n_miss++; $display("FAIL stall_cycle6: out_valid=%b en_msg=%h want 1,%h", out_valid, en_msg, C2); end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_miss++; $display("FAIL stall_release: out_valid=%b in_ready=%b want 0,1", out_valid, in_ready); end
        $display("kat2 stall: pt=%h key=%h ct=%h", P2, K2, C2);
    endtask

    task automatic test_ignore_busy();
        int k;
        int bad;
        out_ready = 1'b1;
        present(P1, K1);
        in_valid = 1'b1; in_msg = P2; cipher_key = K2;
        k = 1; bad = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            if (in_ready !== 1'b0) bad++;
            @(negedge clk);
            k++;
        end
        n_vec++; if (bad != 0) begin n_miss++; $display("FAIL busy_in_ready: %0d cycles high, want 0", bad); end
        n_vec++; if (k != 11) begin n_miss++; $display("FAIL busy_latency: got %0d want 11", k); end
        n_vec++; if (en_msg !== C1 || in_ready !== 1'b0) begin n_miss++; $display("FAIL busy_ct: got %h ready=%b want %h,0", en_msg, in_ready, C1); end
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_miss++; $display("FAIL busy_release: out_valid=%b in_ready=%b want 0,1", out_valid, in_ready); end
        $display("ignore-busy: ct=%h", C1);
    endtask

    task automatic test_reset_mid();
        int k;
        int bad;
        bit got;
        out_ready = 1'b1;
        present(P2, K2);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || en_msg !== '0) begin n_miss++; $display("FAIL midreset_async: out_valid=%b in_ready=%b en_msg=%h want 0,1,0", out_valid, in_ready, en_msg); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
            @(negedge clk);
        end
        n_vec++; if (bad != 0) begin n_miss++; $display("FAIL midreset_abort: %0d cycles with output/not-ready, want 0", bad); end
        present(P1, K1);
        wait_valid(20, k, got);
        n_vec++; if (!got || k != 11 || en_msg !== C1) begin n_miss++; $display("FAIL midreset_next: got %h at %0d want %h at 11", en_msg, got ? k : -1, C1); end
        @(negedge clk);
        $display("mid-round reset: next ct=%h", en_msg);
    endtask

    task automatic test_back_to_back();
        logic [127:0] idle_msg;
        logic         exp_valid;
        logic         exp_ready;
        idle_msg  = ZEROIZE ? 128'h0 : C1;
        out_ready = 1'b1;
        in_valid  = 1'b1; in_msg = P1; cipher_key = K1;
        @(negedge clk);
        in_msg = P2; cipher_key = K2;
        for (int k = 1; k <= 23; k++) begin
            exp_valid = (k == 11 || k == 23);
            exp_ready = (k == 12);
            n_vec++;
            if (out_valid !== exp_valid || in_ready !== exp_ready) begin
                n_miss++;
                $display("FAIL b2b_ctrl_k%0d: out_valid=%b in_ready=%b want %b,%b", k, out_valid, in_ready, exp_valid, exp_ready);
            end
            if (k >= 11) begin
                n_vec++;
                if (en_msg !== (k == 11 ? C1 : (k == 23 ? C2 : idle_msg))) begin
                    n_miss++;
                    $display("FAIL b2b_msg_k%0d: got %h want %h", k, en_msg, k == 11 ? C1 : (k == 23 ? C2 : idle_msg));
                end
            end
            if (k == 13) in_valid = 1'b0;
            if (k < 23) @(negedge clk);
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL b2b_end: out_valid=%b want 0", out_valid); end
        $display("back-to-back: ct1=%h ct2=%h", C1, C2);
    endtask

    task automatic test_random_roundtrip();
        logic [127:0] pt, key, exp, rec;
        int k;
        int stall;
        bit got;
        for (int n = 0; n < 100; n++) begin
            pt    = {$urandom, $urandom, $urandom, $urandom};
            key   = {$urandom, $urandom, $urandom, $urandom};
            stall = $urandom_range(0, 3);
            exp   = ref_encrypt(pt, key);
            out_ready = (stall == 0);
            present(pt, key);
            wait_valid(20, k, got);
            n_vec++; if (!got || k != 11) begin n_miss++; $display("FAIL rand%0d_latency: got %0d want 11", n, got ? k : -1); end
            n_vec++; if (en_msg !== exp) begin n_miss++; $display("FAIL rand%0d_ct: got %h want %h", n, en_msg, exp); end
            rec = ref_decrypt(en_msg, key);
            n_vec++; if (rec !== pt) begin n_miss++; $display("FAIL rand%0d_roundtrip: got %h want %h", n, rec, pt); end
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                n_vec++;
                if (out_valid !== 1'b1 || en_msg !== exp) begin
                    n_miss++;
                    $display("FAIL rand%0d_stall: out_valid=%b en_msg=%h want 1,%h", n, out_valid, en_msg, exp);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL rand%0d_handshake: out_valid=%b want 0", n, out_valid); end
            $display("rand %0d: pt=%h key=%h ct=%h stall=%0d", n, pt, key, exp, stall);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_msg = '0; cipher_key = '0;
        build_tables();
        test_reset();
        test_kat_latency();
        test_stall();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        test_random_roundtrip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/aes128_encrypt_iter.md
AES128_ENCRYPT_ITER -- requirements
Module: aes128_encrypt_iter

Interface
REQ-001 Parameters: none; round count fixed at 10 (AES-128 only).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  plaintext/key present on in_msg/cipher_key.
REQ-005 in_ready  output  1  block idle and able to accept a new block.
REQ-006 in_msg  input  128  plaintext; bits [0:7] = byte 0, bit 0 = MSB of byte 0 (FIPS-197 order).
REQ-007 cipher_key  input  128  AES-128 key, same byte order as in_msg.
REQ-008 out_valid  output  1  en_msg holds a valid ciphertext.
REQ-009 out_ready  input  1  downstream accepts en_msg.
REQ-010 en_msg  output  128  ciphertext, same byte order as in_msg.

Function
REQ-011 Block SHALL compute FIPS-197 AES-128 encryption, bit-exact with the team's aes128_decryption as inverse.
REQ-012 FSM states: IDLE, ROUND, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-013 Input handshake: in_valid&in_ready at edge T; at T, state <= in_msg^cipher_key, key register <= cipher_key, round counter <= 1, FSM -> ROUND.
REQ-014 ROUND: one round per cycle -- SubBytes, ShiftRows, MixColumns (skipped in round 10), AddRoundKey with round key generated on the fly from key register and Rcon(round).
REQ-015 Rcon sequence SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-016 Round counter 4 bits; after round 10 completes at edge T+10, FSM -> DONE; out_valid high from T+10 (latency 10 cycles from accepting edge).
REQ-017 DONE: en_msg and out_valid held stable until out_valid&out_ready; at that edge FSM -> IDLE, out_valid -> 0.
REQ-018 Max throughput one block per 12 cycles with out_ready held high; no overlap of blocks.
REQ-019 in_valid while not in IDLE SHALL be ignored (no capture, no state change).
REQ-020 in_msg/cipher_key changes after the accepting edge SHALL NOT affect the result.
REQ-021 out_ready low in DONE SHALL stall indefinitely without data corruption; out_ready outside DONE ignored.
REQ-022 S-box SHALL be combinational (16 instances), result registered once per round; no multi-cycle paths.

Reset
REQ-023 rst_n low SHALL immediately force FSM=IDLE, round counter=0, out_valid=0, in_ready=1 (after release), state/key registers=0, en_msg=0.
REQ-024 Reset asserted mid-ROUND or in DONE SHALL abort the block; no ciphertext emitted for it.
REQ-025 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro AES_ENC_ZEROIZE_EN: when defined, state and key registers SHALL clear to 0 on the output handshake edge and en_msg SHALL read 0 whenever out_valid=0.
REQ-027 Without AES_ENC_ZEROIZE_EN, en_msg SHALL retain the last ciphertext after handshake until the next block completes; registers are not cleared.

Verification
REQ-028 Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1 -> en_msg=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept, for 1 cycle.
REQ-029 Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready=0 for 5 cycles in DONE -> en_msg=3925841d02dc09fbdc118597196a0b32 held stable, out_valid high throughout, handshake on 6th cycle.
REQ-030 Second in_valid with different data asserted during ROUND -> ignored; first ciphertext correct; in_ready=0 until DONE handshake.
REQ-031 rst_n pulsed low at round 5 -> out_valid=0, in_ready=1 after release, next block (REQ-028 vector) correct.
REQ-032 Two back-to-back blocks (REQ-028 then REQ-029 vectors), in_valid held high -> second accept 12 cycles after first, both ciphertexts correct; with AES_ENC_ZEROIZE_EN en_msg=0 between outputs, without it holds 69c4e0d8....
REQ-033 Round-trip: 100 random key/pt pairs through this block then aes128_decryption -> recovered plaintext equals input.
